rvref_bus_responder: RTL and testbench

Target end of the rvref core's memory bus. Accepts single-beat read/write requests, services them from a word RAM or the 32-entry architectural register file window, and returns completion after a fixed number of wait states. Sits between the rvref core and on-chip storage; one outstanding transaction at a time.

---
 rtl/rvref_bus_pkg.sv | 7 +
 rtl/rvref_regfile.sv | 19 +
 rtl/rvref_bus_responder.sv | 104 ++++++++++
 tb/tb_rvref_bus_responder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/rvref_bus_pkg.sv
// rvref_bus_pkg: shared constants, region decode and responder state encodings for the rvref bus
package rvref_bus_pkg;
  localparam logic [26:0] REG_FILE_BASE = 27'h7000000;
  localparam int NUM_LANES = 4;
  typedef enum logic [1:0] {REGION_RAM, REGION_REGFILE, REGION_UNMAPPED} region_e;
  typedef enum logic [1:0] {ST_IDLE, ST_CAPTURE, ST_WAIT, ST_RESPOND} state_e;
endpackage

// File: rtl/rvref_regfile.sv
// rvref_regfile: 32x32 register window, synchronous write with x0 discard, combinational read
module rvref_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  idx,
  input  logic [31:0] wdata,
  output logic [31:0] rdata
);
  logic [31:0] regs_q [32];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we && idx != 5'd0) begin
      regs_q[idx] <= wdata;
    end
  end
  assign rdata = regs_q[idx];
endmodule

// File: rtl/rvref_bus_responder.sv
// rvref_bus_responder: single-outstanding bus target over word RAM and register window; RVREF_BUS_ERR_EN adds busError
module rvref_bus_responder
  import rvref_bus_pkg::*;
#(
  parameter int MEM_ADDR_BITS = 10,
  parameter int WAIT_STATES   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  input  logic        writeEnable,
  input  logic [3:0]  writeMask,
  input  logic        transactionBegin,
  output logic        transactionEnd,
  output logic [31:0] readData,
  output logic        busy
`ifdef RVREF_BUS_ERR_EN
  , output logic      busError
`endif
);
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d, mask_q, mask_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, rf_rdata;
  logic we_q, we_d, end_q, end_d, go;
  region_e region;
  logic [31:0] mem [1 << MEM_ADDR_BITS];
  logic [MEM_ADDR_BITS-1:0] word;
  assign word = addr_q[MEM_ADDR_BITS+1:2];
  assign region = addr_q[31:5] == REG_FILE_BASE ? REGION_REGFILE :
                  addr_q[31:MEM_ADDR_BITS+2] == '0 ? REGION_RAM : REGION_UNMAPPED;
  assign go = (state_q == ST_CAPTURE && cnt_q == 4'd0) || (state_q == ST_WAIT && cnt_q == 4'd1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    mask_d  = mask_q;
    rdata_d = rdata_q;
    end_d   = go;
    unique case (state_q)
      ST_IDLE: if (transactionBegin) begin
        state_d = ST_CAPTURE;
        cnt_d   = 4'(WAIT_STATES);
        addr_d  = address;
        wdata_d = writeData;
        we_d    = writeEnable;
        mask_d  = writeMask;
      end
      ST_CAPTURE: state_d = go ? ST_RESPOND : ST_WAIT;
      ST_WAIT: begin
        cnt_d   = cnt_q - 4'd1;
        state_d = go ? ST_RESPOND : ST_WAIT;
      end
      ST_RESPOND: state_d = ST_IDLE;
    endcase
    if (go && !we_q)
      rdata_d = region == REGION_RAM ? mem[word] : region == REGION_REGFILE ? rf_rdata : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      mask_q  <= '0;
      rdata_q <= '0;
      end_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
      end_q   <= end_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && go && we_q && region == REGION_RAM)
      for (int i = 0; i < NUM_LANES; i++)
        if (mask_q[i]) mem[word][8*i +: 8] <= wdata_q[8*i +: 8];
  end
  rvref_regfile u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (go && we_q && region == REGION_REGFILE),
    .idx   (addr_q[4:0]),
    .wdata (wdata_q),
    .rdata (rf_rdata)
  );
  assign transactionEnd = end_q;
  assign readData       = rdata_q;
  assign busy           = state_q != ST_IDLE;
`ifdef RVREF_BUS_ERR_EN
  logic err_q, err_d;
  assign err_d = go && region == REGION_UNMAPPED;
  always_ff @(posedge clk) err_q <= rst ? 1'b0 : err_d;
  assign busError = err_q || (transactionBegin && busy);
`endif
endmodule

// File: tb/tb_rvref_bus_responder.sv
// tb_rvref_bus_responder: scoreboard bench for rvref_bus_responder at WAIT_STATES=1 and 0 (RVREF_BUS_ERR_EN aware)
module tb_rvref_bus_responder;
  localparam int W1 = 1;
`ifdef RVREF_BUS_ERR_EN
  localparam bit OVL_ERR = 1'b1;
`else
  localparam bit OVL_ERR = 1'b0;
`endif
  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic        err;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] address = '0, writeData = '0;
  logic writeEnable = 1'b0, begin1 = 1'b0, begin0 = 1'b0;
  logic [3:0] writeMask = '0;
  logic end1, end0, busy1, busy0, err1, err0;
  logic [31:0] rd1, rd0;
  int cyc = 0, errors = 0, checks = 0;
  exp_t q1[$], q0[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  rvref_bus_responder #(.MEM_ADDR_BITS(10), .WAIT_STATES(W1)) dut (
    .clk(clk), .rst(rst), .address(address), .writeData(writeData),
    .writeEnable(writeEnable), .writeMask(writeMask), .transactionBegin(begin1),
    .transactionEnd(end1), .readData(rd1), .busy(busy1)
`ifdef RVREF_BUS_ERR_EN
    , .busError(err1)
`endif
  );
  rvref_bus_responder #(.MEM_ADDR_BITS(10), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .address(address), .writeData(writeData),
    .writeEnable(writeEnable), .writeMask(writeMask), .transactionBegin(begin0),
    .transactionEnd(end0), .readData(rd0), .busy(busy0)
`ifdef RVREF_BUS_ERR_EN
    , .busError(err0)
`endif
  );
`ifndef RVREF_BUS_ERR_EN
  assign err1 = 1'b0;
  assign err0 = 1'b0;
`endif
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (end1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL d1_unexpected_end: end=1 at cycle %0d expected no end", cyc);
      end else begin
        e = q1.pop_front();
        chk("d1_end_cycle", 32'(cyc), 32'(e.cyc));
        chk("d1_readData", rd1, e.data);
`ifdef RVREF_BUS_ERR_EN
        chk("d1_busError", 32'(err1), 32'(e.err));
`endif
      end
    end else if (q1.size() != 0 && cyc > q1[0].cyc) begin
      e = q1.pop_front();
      checks++;
      errors++;
      $display("FAIL d1_missing_end: no end by cycle %0d expected at %0d", cyc, e.cyc);
    end
    if (end0) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL d0_unexpected_end: end=1 at cycle %0d expected no end", cyc);
      end else begin
        e = q0.pop_front();
        chk("d0_end_cycle", 32'(cyc), 32'(e.cyc));
        chk("d0_readData", rd0, e.data);
`ifdef RVREF_BUS_ERR_EN
        chk("d0_busError", 32'(err0), 32'(e.err));
`endif
      end
    end else if (q0.size() != 0 && cyc > q0[0].cyc) begin
      e = q0.pop_front();
      checks++;
      errors++;
      $display("FAIL d0_missing_end: no end by cycle %0d expected at %0d", cyc, e.cyc);
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic scramble();
    address     = 32'($urandom);
    writeData   = 32'($urandom);
    writeEnable = 1'($urandom);
    writeMask   = 4'($urandom);
  endtask
  task automatic wait_idle(input bit w0);
    int i;
    for (i = 0; i < 20; i++) begin
      step();
      if (!(w0 ? busy0 : busy1)) break;
    end
    chk("idle_timeout", 32'(i >= 20), 32'(0));
  endtask
  task automatic xact(input bit w0, input logic [31:0] a, input logic [31:0] d, input logic we,
                      input logic [3:0] m, input logic [31:0] er, input logic ee);
    address     = a;
    writeData   = d;
    writeEnable = we;
    writeMask   = m;
    if (w0) begin
      begin0 = 1'b1;
      q0.push_back('{cyc + 2, er, ee});
    end else begin
      begin1 = 1'b1;
      q1.push_back('{cyc + 2 + W1, er, ee});
    end
    step();
    begin0 = 1'b0;
    begin1 = 1'b0;
    scramble();
    chk("busy_after_capture", 32'(w0 ? busy0 : busy1), 32'(1));
    wait_idle(w0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end
  initial begin
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_end1", 32'(end1), 32'(0));
    chk("rst_rd1", rd1, 32'h0);
    chk("rst_busy1", 32'(busy1), 32'(0));
    chk("rst_end0", 32'(end0), 32'(0));
    chk("rst_rd0", rd0, 32'h0);
    chk("rst_busy0", 32'(busy0), 32'(0));
    while (cyc < 5) step();
    xact(0, 32'h10, 32'hDEADBEEF, 1, 4'hF, 32'h0, 0);
    xact(0, 32'h10, 32'h0, 0, 4'h0, 32'hDEADBEEF, 0);
    xact(0, 32'h13, 32'h000000AA, 1, 4'h1, 32'hDEADBEEF, 0);
    xact(0, 32'h10, 32'h0, 0, 4'h0, 32'hDEADBEAA, 0);
    xact(0, 32'h10, 32'hFFFFFFFF, 1, 4'h0, 32'hDEADBEAA, 0);
    xact(0, 32'h10, 32'h0, 0, 4'h0, 32'hDEADBEAA, 0);
    xact(0, 32'hE0000003, 32'h12345678, 1, 4'h0, 32'hDEADBEAA, 0);
    xact(0, 32'hE0000003, 32'h0, 0, 4'h0, 32'h12345678, 0);
    xact(0, 32'hE0000000, 32'hFFFFFFFF, 1, 4'hF, 32'h12345678, 0);
    xact(0, 32'hE0000000, 32'h0, 0, 4'h0, 32'h0, 0);
    xact(0, 32'h10, 32'h0, 0, 4'h0, 32'hDEADBEAA, 0);
    xact(0, 32'h80000000, 32'h0, 0, 4'h0, 32'h0, 1);
    xact(0, 32'h80000010, 32'h99999999, 1, 4'hF, 32'h0, 1);
    xact(0, 32'h10, 32'h0, 0, 4'h0, 32'hDEADBEAA, 0);
    xact(0, 32'hE0000003, 32'h0, 0, 4'h0, 32'h12345678, 0);
    address     = 32'h10;
    writeEnable = 1'b0;
    begin1      = 1'b1;
    q1.push_back('{cyc + 2 + W1, 32'hDEADBEAA, OVL_ERR});
    step();
    begin1 = 1'b0;
    step();
    address = 32'hE0000003;
    begin1  = 1'b1;
    step();
    step();
    begin1 = 1'b0;
    chk("overlap_idle_after", 32'(busy1), 32'(0));
    xact(0, 32'h20, 32'h11111111, 1, 4'hF, 32'hDEADBEAA, 0);
    address     = 32'h20;
    writeData   = 32'h55;
    writeEnable = 1'b1;
    writeMask   = 4'hF;
    begin1      = 1'b1;
    step();
    begin1 = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_end", 32'(end1), 32'(0));
    chk("midrst_rd", rd1, 32'h0);
    chk("midrst_busy", 32'(busy1), 32'(0));
    xact(0, 32'h20, 32'h0, 0, 4'h0, 32'h11111111, 0);
    xact(0, 32'hE0000003, 32'h0, 0, 4'h0, 32'h0, 0);
    xact(1, 32'h40, 32'hCAFEF00D, 1, 4'hF, 32'h0, 0);
    xact(1, 32'h40, 32'h0, 0, 4'h0, 32'hCAFEF00D, 0);
    repeat (4) step();
    chk("drain_q1", 32'(q1.size()), 32'(0));
    chk("drain_q0", 32'(q0.size()), 32'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
